nco_multi_ch: RTL and testbench
===============================

// Module: nco_multi_ch
// PURPOSE
//  Parametrised multi-channel NCO: one phase accumulator per channel, each with a
//  programmable frequency word and phase offset, producing sine and cosine.
//  Double-buffered config; a common sync strobe applies it and aligns all channels.
//  Keeps the test-mode frequency offset and nco_test_en flag; sits in the DDC mixer path.
// PARAMETERS
//  NUM_CH   2   channel count (>=1)
//  PHASE_W  32  accumulator / frequency word width
//  LUT_AW   10  quarter-wave ROM address bits (phase resolution LUT_AW+2 bits)
//  OUT_W    16  signed output sample width
//  TEST_W   15  nco_test width (requires TEST_W <= PHASE_W-1)
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 reset, asynchronous, active-low
//  clken        in   1                 pipeline advance enable
//  cfg_wr       in   1                 write freq_word/phase_off into shadow regs of ch_sel
//  ch_sel       in   max(1,$clog2(NUM_CH)) channel index for cfg_wr
//  freq_word    in   PHASE_W           phase increment (unsigned)
//  phase_off    in   PHASE_W           phase offset (unsigned, modulo 2^PHASE_W)
//  sync_clr     in   1                 shadow->active, clear all accumulators
//  nco_test     in   TEST_W            [TEST_W-1:1] frequency offset, [0] test flag
//  sin_o        out  NUM_CH*OUT_W      signed sines, channel k at [k*OUT_W +: OUT_W]
//  cos_o        out  NUM_CH*OUT_W      signed cosines, same packing
//  out_valid    out  1                 sin_o/cos_o valid this cycle
//  nco_test_en  out  1                 registered nco_test[0]
// BEHAVIOUR
//  Reset: shadow/active regs, accumulators, pipeline, sin_o, cos_o, out_valid and nco_test_en all 0.
//  cfg_wr: shadow[ch_sel] <= {freq_word, phase_off}; ch_sel >= NUM_CH ignored. Active unaffected.
//  sync_clr: active <= shadow (all ch), acc <= 0, valid pipe flushed. Acts regardless of clken.
//  cfg_wr + sync_clr same cycle: the written value reaches active directly (write-through).
//  Test offset: toff = {nco_test[TEST_W-1:1]} << (PHASE_W-TEST_W-1), top 2 bits 0;
//    defaults: bits [29:16]. nco_test_en <= nco_test[0] every cycle (not clken-gated).
//  Per-channel pipeline, advancing only when clken=1:
//   S1 acc <= acc + active_freq + toff (mod 2^PHASE_W, wrap silent)
//   S2 p = acc + phase_off; q = p[PW-1:PW-2], a = p[PW-3 -: LUT_AW];
//      sine addr = q[0] ? ~a : a, sign = q[1]; cosine uses q+1 likewise
//   S3 ROM read (registered)
//   S4 outputs <= sign ? -rom : rom
//  Latency: 4 clken cycles from accumulator to output. First output after
//    sync_clr/reset reflects phase 0 (acc=0 + offset).
//  out_valid: 4-stage valid shift reg loaded with 1 each clken cycle; cleared by
//    reset/sync_clr; out_valid = valid[3] & clken. clken=0: all state and outputs hold.
//  ROM[k] = round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)); half-LSB offset makes
//    mirror symmetric, so negation never overflows (no -2^(OUT_W-1)).
// STRUCTURE
//  Package nco_pkg: ROM amplitude constant, quadrant encoding, toff shift function.
//  Sub-module nco_qw_rom: synchronous dual-read quarter-wave ROM (sine+cosine
//    addresses), one instance per channel; generate loop over channels.
// TESTING (defaults, LUT_AW=10)
//  Reset, freq 0 on ch0, sync_clr -> out_valid high 4 cycles later; sin=25, cos=32767 constant.
//  ch0 freq 0x4000_0000 -> sin sequence 25, 32767, -25, -32767 repeating; cos leads by one sample.
//  freq 0xFFFF_FFFF -> second sample phase 0xFFFF_FFFF: sin=-25, cos=32767; wrap with no glitch.
//  nco_test=15'h0003, freq 0 -> nco_test_en=1 next cycle; phase advances 0x0001_0000/cycle.
//  ch1 cfg_wr phase_off 0x8000_0000 with no sync_clr -> outputs unchanged; after sync_clr
//    ch1 sin=-25 while ch0 sin=25, out_valid low 4 cycles.
//  clken low 3 cycles mid-stream -> outputs frozen, out_valid 0, sequence resumes with no skip.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the multi-channel NCO: quadrant encoding, ROM amplitude,
// test-offset shift and the constant-time quarter-wave table generator.
package nco_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  function automatic int rom_amp(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int toff_shift(input int phase_w, input int test_w);
    return phase_w - test_w - 1;
  endfunction

  // Taylor series keeps table generation free of tool-specific math functions.
  function automatic real qw_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int rom_entry(input int k, input int lut_aw, input int out_w);
    real x;
    x = (3.14159265358979323846 / 2.0) * ($itor(k) + 0.5) / $itor(1 << lut_aw);
    return $rtoi($itor(rom_amp(out_w)) * qw_sin(x) + 0.5);
  endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Synchronous dual-read quarter-wave sine ROM holding unsigned magnitudes.
module nco_qw_rom
  import nco_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr_a,
  input  logic [LUT_AW-1:0] addr_b,
  output logic [OUT_W-2:0]  data_a,
  output logic [OUT_W-2:0]  data_b
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [OUT_W-2:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int VAL = rom_entry(k, LUT_AW, OUT_W);
    assign rom[k] = VAL[OUT_W-2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/nco_multi_ch.sv
// Multi-channel NCO with double-buffered frequency/phase config, common sync strobe
// and a four-stage accumulator-to-output pipeline per channel.
module nco_multi_ch
  import nco_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int PHASE_W = 32,
  parameter  int LUT_AW  = 10,
  parameter  int OUT_W   = 16,
  parameter  int TEST_W  = 15,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clken,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic [PHASE_W-1:0]      phase_off,
  input  logic                    sync_clr,
  input  logic [TEST_W-1:0]       nco_test,
  output logic [NUM_CH*OUT_W-1:0] sin_o,
  output logic [NUM_CH*OUT_W-1:0] cos_o,
  output logic                    out_valid,
  output logic                    nco_test_en
);

  localparam int TSH = toff_shift(PHASE_W, TEST_W);
  localparam int PB  = LUT_AW + 2;

  logic [PHASE_W-1:0] toff;
  logic [3:0]         valid;

  assign toff      = {{(PHASE_W - TEST_W + 1){1'b0}}, nco_test[TEST_W-1:1]} << TSH;
  assign out_valid = valid[3] & clken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= '0;
      nco_test_en <= 1'b0;
    end else begin
      nco_test_en <= nco_test[0];
      if (sync_clr) valid <= '0;
      else if (clken) valid <= {valid[2:0], 1'b1};
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PHASE_W-1:0] sh_freq, sh_off, act_freq, act_off, acc;
    logic [PB-1:0]      ptop;
    logic [LUT_AW-1:0]  a, addr_s, addr_c;
    logic [1:0]         sgn2, sgn3;
    logic [OUT_W-2:0]   mag_s, mag_c;
    logic [OUT_W-1:0]   out_s, out_c;
    logic               hit;
    quad_e              q_s, q_c;

    assign hit = cfg_wr && (int'(ch_sel) == k);

    // A write in the sync cycle goes straight through to the active registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sh_freq  <= '0;
        sh_off   <= '0;
        act_freq <= '0;
        act_off  <= '0;
      end else begin
        if (hit) begin
          sh_freq <= freq_word;
          sh_off  <= phase_off;
        end
        if (sync_clr) begin
          act_freq <= hit ? freq_word : sh_freq;
          act_off  <= hit ? phase_off : sh_off;
        end
      end
    end

    always_comb begin
      q_s = quad_e'(ptop[PB-1 -: 2]);
      q_c = quad_e'(ptop[PB-1 -: 2] + 2'd1);
      a   = ptop[LUT_AW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc    <= '0;
        ptop   <= '0;
        addr_s <= '0;
        addr_c <= '0;
        sgn2   <= '0;
        sgn3   <= '0;
        out_s  <= '0;
        out_c  <= '0;
      end else begin
        if (sync_clr) acc <= '0;
        else if (clken) acc <= acc + act_freq + toff;
        if (clken) begin
          ptop   <= PB'((acc + act_off) >> (PHASE_W - PB));
          addr_s <= (q_s == QUAD_1 || q_s == QUAD_3) ? ~a : a;
          addr_c <= (q_c == QUAD_1 || q_c == QUAD_3) ? ~a : a;
          sgn2   <= {(q_s == QUAD_2 || q_s == QUAD_3), (q_c == QUAD_2 || q_c == QUAD_3)};
          sgn3   <= sgn2;
          out_s  <= sgn3[1] ? -{1'b0, mag_s} : {1'b0, mag_s};
          out_c  <= sgn3[0] ? -{1'b0, mag_c} : {1'b0, mag_c};
        end
      end
    end

    nco_qw_rom #(
      .LUT_AW(LUT_AW),
      .OUT_W (OUT_W)
    ) u_rom (
      .clk   (clk),
      .rst   (rst),
      .en    (clken),
      .addr_a(addr_s),
      .addr_b(addr_c),
      .data_a(mag_s),
      .data_b(mag_c)
    );

    assign sin_o[k*OUT_W +: OUT_W] = out_s;
    assign cos_o[k*OUT_W +: OUT_W] = out_c;
  end

endmodule

// File: tb/tb_nco_multi_ch.sv
// Directed bench for nco_multi_ch at default parameters (2 channels, 10-bit quarter-wave LUT).
module tb_nco_multi_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken;
  logic        cfg_wr;
  logic [0:0]  ch_sel;
  logic [31:0] freq_word;
  logic [31:0] phase_off;
  logic        sync_clr;
  logic [14:0] nco_test;
  logic [31:0] sin_o;
  logic [31:0] cos_o;
  logic        out_valid;
  logic        nco_test_en;

  logic signed [15:0] s0, c0, s1, c1;
  int total = 0;
  int bad   = 0;
  int seq [4] = '{25, 32767, -25, -32767};

  assign s0 = sin_o[15:0];
  assign c0 = cos_o[15:0];
  assign s1 = sin_o[31:16];
  assign c1 = cos_o[31:16];

  always #5 clk = ~clk;

  nco_multi_ch #(
    .NUM_CH (2),
    .PHASE_W(32),
    .LUT_AW (10),
    .OUT_W  (16),
    .TEST_W (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .cfg_wr     (cfg_wr),
    .ch_sel     (ch_sel),
    .freq_word  (freq_word),
    .phase_off  (phase_off),
    .sync_clr   (sync_clr),
    .nco_test   (nco_test),
    .sin_o      (sin_o),
    .cos_o      (cos_o),
    .out_valid  (out_valid),
    .nco_test_en(nco_test_en)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_cfg(input logic ch, input logic [31:0] f, input logic [31:0] o,
                           input logic sync);
    cfg_wr    = 1'b1;
    ch_sel    = ch;
    freq_word = f;
    phase_off = o;
    sync_clr  = sync;
    tick(1);
    cfg_wr   = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clken = 1'b1; cfg_wr = 1'b0; ch_sel = '0; freq_word = '0;
    phase_off = '0; sync_clr = 1'b0; nco_test = 15'h0001;
    tick(3);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (sin_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_sin: got %h want 0", sin_o); end
    total++; if (cos_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_cos: got %h want 0", cos_o); end
    total++; if (nco_test_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_test_en: got %0b want 0", nco_test_en); end
    nco_test = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_valid%0d: got %0b want 0", i, out_valid); end
    end
    tick(1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_first_valid: got %0b want 1", out_valid); end
    total++; if (s0 !== 16'sd25) begin bad++; $display("[TB] FAIL post_reset_sin: got %0d want 25", s0); end
  endtask

  task automatic test_static();
    drive_cfg(1'b0, 32'h0, 32'h0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL static_flush: got %0b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL static_latency%0d: got %0b want 0", i, out_valid); end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL static_valid%0d: got %0b want 1", i, out_valid); end
      total++; if (s0 !== 16'sd25) begin bad++; $display("[TB] FAIL static_sin%0d: got %0d want 25", i, s0); end
      total++; if (c0 !== 16'sd32767) begin bad++; $display("[TB] FAIL static_cos%0d: got %0d want 32767", i, c0); end
    end
  endtask

  task automatic test_quarter();
    drive_cfg(1'b0, 32'h4000_0000, 32'h0, 1'b1);
    tick(4);
    for (int i = 0; i < 8; i++) begin
      total++; if (s0 !== 16'(seq[i % 4])) begin bad++; $display("[TB] FAIL quarter_sin%0d: got %0d want %0d", i, s0, seq[i % 4]); end
      total++; if (c0 !== 16'(seq[(i + 1) % 4])) begin bad++; $display("[TB] FAIL quarter_cos%0d: got %0d want %0d", i, c0, seq[(i + 1) % 4]); end
      tick(1);
    end
  endtask

  task automatic test_wrap();
    drive_cfg(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    tick(4);
    for (int i = 0; i < 5; i++) begin
      total++; if (s0 !== ((i == 0) ? 16'sd25 : -16'sd25)) begin bad++; $display("[TB] FAIL wrap_sin%0d: got %0d want %0d", i, s0, (i == 0) ? 25 : -25); end
      total++; if (c0 !== 16'sd32767) begin bad++; $display("[TB] FAIL wrap_cos%0d: got %0d want 32767", i, c0); end
      tick(1);
    end
  endtask

  task automatic test_offset();
    nco_test = 15'h0003;
    tick(1);
    total++; if (nco_test_en !== 1'b1) begin bad++; $display("[TB] FAIL test_en_set: got %0b want 1", nco_test_en); end
    drive_cfg(1'b0, 32'h0, 32'h0, 1'b1);
    tick(4);
    for (int i = 0; i < 17; i++) begin
      total++; if (s0 !== ((i < 16) ? 16'sd25 : 16'sd75)) begin bad++; $display("[TB] FAIL offset_sin%0d: got %0d want %0d", i, s0, (i < 16) ? 25 : 75); end
      total++; if (c0 !== 16'sd32767) begin bad++; $display("[TB] FAIL offset_cos%0d: got %0d want 32767", i, c0); end
      if (i < 16) tick(1);
    end
    nco_test = '0;
    tick(1);
    total++; if (nco_test_en !== 1'b0) begin bad++; $display("[TB] FAIL test_en_clear: got %0b want 0", nco_test_en); end
  endtask

  task automatic test_ch1_phase();
    drive_cfg(1'b0, 32'h0, 32'h0, 1'b1);
    tick(4);
    total++; if (s1 !== 16'sd25) begin bad++; $display("[TB] FAIL ch1_initial_sin: got %0d want 25", s1); end
    drive_cfg(1'b1, 32'h0, 32'h8000_0000, 1'b0);
    tick(3);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ch1_shadow_valid: got %0b want 1", out_valid); end
    total++; if (s1 !== 16'sd25) begin bad++; $display("[TB] FAIL ch1_shadow_sin: got %0d want 25", s1); end
    total++; if (c1 !== 16'sd32767) begin bad++; $display("[TB] FAIL ch1_shadow_cos: got %0d want 32767", c1); end
    sync_clr = 1'b1;
    tick(1);
    sync_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ch1_sync_low%0d: got %0b want 0", i, out_valid); end
      tick(1);
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ch1_sync_valid: got %0b want 1", out_valid); end
    total++; if (s0 !== 16'sd25) begin bad++; $display("[TB] FAIL ch1_ch0_sin: got %0d want 25", s0); end
    total++; if (c0 !== 16'sd32767) begin bad++; $display("[TB] FAIL ch1_ch0_cos: got %0d want 32767", c0); end
    total++; if (s1 !== -16'sd25) begin bad++; $display("[TB] FAIL ch1_sin: got %0d want -25", s1); end
    total++; if (c1 !== -16'sd32767) begin bad++; $display("[TB] FAIL ch1_cos: got %0d want -32767", c1); end
  endtask

  task automatic test_clken();
    drive_cfg(1'b0, 32'h4000_0000, 32'h0, 1'b1);
    tick(4);
    total++; if (s0 !== 16'sd25) begin bad++; $display("[TB] FAIL clken_s0: got %0d want 25", s0); end
    tick(1);
    total++; if (s0 !== 16'sd32767) begin bad++; $display("[TB] FAIL clken_s1: got %0d want 32767", s0); end
    clken = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL clken_gate_valid: got %0b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL clken_hold_valid%0d: got %0b want 0", i, out_valid); end
      total++; if (s0 !== 16'sd32767) begin bad++; $display("[TB] FAIL clken_hold_sin%0d: got %0d want 32767", i, s0); end
      total++; if (c0 !== -16'sd25) begin bad++; $display("[TB] FAIL clken_hold_cos%0d: got %0d want -25", i, c0); end
    end
    clken = 1'b1;
    for (int j = 2; j < 6; j++) begin
      tick(1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL clken_resume_valid%0d: got %0b want 1", j, out_valid); end
      total++; if (s0 !== 16'(seq[j % 4])) begin bad++; $display("[TB] FAIL clken_resume_sin%0d: got %0d want %0d", j, s0, seq[j % 4]); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_quarter();
    test_wrap();
    test_offset();
    test_ch1_phase();
    test_clken();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
